// File: rtl/sprite_pixel_fetch.sv
// ---------------------------------------------------------------------------
// sprite_pixel_fetch
//
// This stage sits in the pixel pipeline just after the sprite block ROM. It
// maps the current scan coordinate into a ROM address for a sprite whose
// position is sampled once per frame. It then merges the ROM word with the
// background colour and produces a registered pixel. The latency is a fixed
// two clocks.
//
// Optional feature macro: SPRITE_COLOR_KEY_EN
//   defined   -> a ROM word equal to COLOR_KEY is transparent. It shows bg_rgb
//                and is not counted as a hit.
//   undefined -> every in-window sprite pixel is opaque.
//
// Ports
//   clk         pixel clock; every register updates on its rising edge
//   reset       synchronous, active-high reset
//   video_on    high while pixel_x/pixel_y lie in the visible area
//   pixel_x/y   current scan coordinate (10 bits each)
//   frame_tick  one-clock pulse at the start of vertical blank
//   pos_x_in/y  requested sprite top-left corner, latched on frame_tick
//   bg_rgb      background colour of the current pixel
//   rom_addr    combinational ROM address (the ROM registers it internally)
//   rom_data    ROM word, valid one clock after rom_addr is sampled
//   rgb_out     registered output pixel
//   rgb_valid   registered video_on, aligned with rgb_out
//   hit_count   opaque sprite pixels drawn during the previous frame
// ---------------------------------------------------------------------------
module sprite_pixel_fetch #(
  parameter int          SPRITE_W  = 16,
  parameter int          SPRITE_H  = 16,
  parameter int          ADDR_W    = 8,
  parameter logic [11:0] COLOR_KEY = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              frame_tick,
  input  logic [9:0]        pos_x_in,
  input  logic [9:0]        pos_y_in,
  input  logic [11:0]       bg_rgb,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [11:0]       rgb_out,
  output logic              rgb_valid,
  output logic [ADDR_W:0]   hit_count
);

  localparam logic [ADDR_W:0] CNT_MAX = '1;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // -------------------------------------------------------------------------
  // Sprite position. It is sampled only on frame_tick, so moving the sprite
  // cannot tear the frame that is being drawn.
  // -------------------------------------------------------------------------
  logic [9:0] pos_x_reg, pos_x_next;
  logic [9:0] pos_y_reg, pos_y_next;

  always_comb begin
    pos_x_next = pos_x_reg;
    pos_y_next = pos_y_reg;
    if (frame_tick) begin
      pos_x_next = pos_x_in;
      pos_y_next = pos_y_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x_reg <= '0;
      pos_y_reg <= '0;
    end else begin
      pos_x_reg <= pos_x_next;
      pos_y_reg <= pos_y_next;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 0: window test and address generation (combinational).
  // The offsets carry an extra sign bit. A scan position left of or above the
  // sprite therefore comes out negative and is rejected. It does not wrap
  // around to a large positive offset, which is how a sprite near column 1023
  // is kept from reappearing at the left edge.
  // -------------------------------------------------------------------------
  logic [10:0] dx;
  logic [10:0] dy;
  logic        dx_in_range;
  logic        dy_in_range;
  logic        in_win;

  assign dx = {1'b0, pixel_x} - {1'b0, pos_x_reg};
  assign dy = {1'b0, pixel_y} - {1'b0, pos_y_reg};

  assign dx_in_range = ~dx[10] && ({1'b0, dx[9:0]} < 11'(SPRITE_W));
  assign dy_in_range = ~dy[10] && ({1'b0, dy[9:0]} < 11'(SPRITE_H));
  assign in_win      = video_on && dx_in_range && dy_in_range;

  // Row-major address into the sprite image, truncated to the ROM width.
  // Outside the window the address is parked at 0.
  assign rom_addr = in_win
                  ? ADDR_W'(21'(dy[9:0]) * 21'(SPRITE_W) + 21'(dx[9:0]))
                  : '0;

  // -------------------------------------------------------------------------
  // Stage 1: side-band data. It travels alongside the address the ROM
  // registers internally, so it lines up with rom_data on the next clock.
  // -------------------------------------------------------------------------
  logic        s1_in_win_reg;
  logic        s1_video_on_reg;
  logic [11:0] s1_bg_rgb_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_in_win_reg   <= 1'b0;
      s1_video_on_reg <= 1'b0;
      s1_bg_rgb_reg   <= 12'h000;
    end else begin
      s1_in_win_reg   <= in_win;
      s1_video_on_reg <= video_on;
      s1_bg_rgb_reg   <= bg_rgb;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: pixel selection.
  // -------------------------------------------------------------------------
  logic pix_opaque;

`ifdef SPRITE_COLOR_KEY_EN
  assign pix_opaque = (rom_data != COLOR_KEY);
`else
  assign pix_opaque = 1'b1;
  // The key colour has no role when keying is disabled.
  logic unused_color_key;
  assign unused_color_key = ^COLOR_KEY;
`endif

  logic        sel_sprite;
  logic [11:0] rgb_out_reg, rgb_out_next;
  logic        rgb_valid_reg;

  // s1_in_win_reg already implies s1_video_on_reg, because in_win includes
  // video_on. Blanked pixels can therefore never select or count sprite data.
  assign sel_sprite = s1_in_win_reg && pix_opaque;

  always_comb begin
    rgb_out_next = 12'h000;
    if (s1_video_on_reg) begin
      rgb_out_next = sel_sprite ? rom_data : s1_bg_rgb_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out_reg   <= 12'h000;
      rgb_valid_reg <= 1'b0;
    end else begin
      rgb_out_reg   <= rgb_out_next;
      rgb_valid_reg <= s1_video_on_reg;
    end
  end

  assign rgb_out   = rgb_out_reg;
  assign rgb_valid = rgb_valid_reg;

  // -------------------------------------------------------------------------
  // Hit counter. It counts the opaque sprite pixels selected in stage 2. On
  // frame_tick the running total is published and the count restarts. A hit
  // on the tick clock itself belongs to the frame that is just starting.
  // -------------------------------------------------------------------------
  logic [ADDR_W:0] run_count_reg, run_count_next;
  logic [ADDR_W:0] hit_count_reg, hit_count_next;

  always_comb begin
    run_count_next = run_count_reg;
    hit_count_next = hit_count_reg;
    if (frame_tick) begin
      hit_count_next = run_count_reg;
      run_count_next = sel_sprite ? CNT_ONE : '0;
    end else if (sel_sprite && (run_count_reg != CNT_MAX)) begin
      run_count_next = run_count_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_count_reg <= '0;
      hit_count_reg <= '0;
    end else begin
      run_count_reg <= run_count_next;
      hit_count_reg <= hit_count_next;
    end
  end

  assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// ---------------------------------------------------------------------------
// tb_sprite_pixel_fetch
//
// Self-checking bench for sprite_pixel_fetch. Stimulus is driven one pixel
// per clock. Every output is compared against a reference that works on
// whole pixels:
//   - the expected colour of each pixel comes from signed integer offsets
//     against the position latched by the most recent frame tick;
//   - the expected hit count comes from summing per-pixel hit flags between
//     frame ticks.
// The ROM is modelled as a registered lookup whose content is selectable.
// ---------------------------------------------------------------------------
module tb_sprite_pixel_fetch;

  localparam int          SW  = 16;
  localparam int          SH  = 16;
  localparam int          AW  = 8;
  localparam logic [11:0] KEY = 12'h000;
  localparam int          SAT = (1 << (AW + 1)) - 1;
`ifdef SPRITE_COLOR_KEY_EN
  localparam int KEY_HITS = 128;
`else
  localparam int KEY_HITS = 256;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          video_on;
  logic [9:0]    pixel_x, pixel_y;
  logic          frame_tick;
  logic [9:0]    pos_x_in, pos_y_in;
  logic [11:0]   bg_rgb;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  logic [11:0]   rgb_out;
  logic          rgb_valid;
  logic [AW:0]   hit_count;

  always #5 clk = ~clk;

  sprite_pixel_fetch #(
    .SPRITE_W  (SW),
    .SPRITE_H  (SH),
    .ADDR_W    (AW),
    .COLOR_KEY (KEY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_tick (frame_tick),
    .pos_x_in   (pos_x_in),
    .pos_y_in   (pos_y_in),
    .bg_rgb     (bg_rgb),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rgb_out    (rgb_out),
    .rgb_valid  (rgb_valid),
    .hit_count  (hit_count)
  );

  // ROM contents:
  //   mode 0: data = address
  //   mode 1: even addresses hold the key colour
  //   mode 2: data is never zero
  int rom_mode = 0;

  function automatic logic [11:0] rom_fn(input int a);
    case (rom_mode)
      0:       return 12'(a);
      1:       return (a % 2 == 0) ? 12'h000 : 12'(12'hF00 + a);
      default: return 12'(12'h800 + a);
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

  function automatic bit is_opaque(input logic [11:0] d);
`ifdef SPRITE_COLOR_KEY_EN
    return d != KEY;
`else
    return (d == d);
`endif
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference-model state
  typedef struct packed {
    logic [11:0] rgb;
    logic        valid;
  } exp_t;

  exp_t q[$];             // expected outputs, oldest first
  int   hits[$];          // hit flag for the pixel driven in each cycle
  int   cyc       = 0;
  int   win_start = 0;    // first cycle whose pixel counts toward the current frame
  int   exp_hit   = 0;
  int   mpos_x    = 0;
  int   mpos_y    = 0;
  bit   started   = 0;

  int          cur_pxi = 0;
  int          cur_pyi = 0;
  logic [11:0] cur_bg  = 12'h000;

  // One pixel clock: check what is due, drive the new pixel, update the model.
  task automatic step(input bit rst, input bit von, input int px, input int py, input bit tick);
    exp_t        e;
    int          dx, dy, addr, sum;
    bit          inw, hit;
    logic [11:0] d;

    @(posedge clk);
    #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      check("rgb_out", rgb_out, e.rgb);
      check("rgb_valid", rgb_valid, e.valid);
    end
    if (started) check("hit_count", hit_count, exp_hit);

    reset      = rst;
    video_on   = von;
    pixel_x    = 10'(px);
    pixel_y    = 10'(py);
    frame_tick = tick;
    pos_x_in   = 10'(cur_pxi);
    pos_y_in   = 10'(cur_pyi);
    bg_rgb     = cur_bg;

    dx   = px - mpos_x;
    dy   = py - mpos_y;
    inw  = von && dx >= 0 && dx < SW && dy >= 0 && dy < SH;
    addr = inw ? ((dy * SW + dx) % (1 << AW)) : 0;
    d    = rom_fn(addr);
    hit  = inw && is_opaque(d);
    e.valid = von;
    e.rgb   = !von ? 12'h000 : (hit ? d : cur_bg);

    #1;
    check("rom_addr", rom_addr, addr);

    if (rst) begin
      for (int i = 0; i < q.size(); i++) q[i] = '{rgb: 12'h000, valid: 1'b0};
      e.rgb     = 12'h000;
      e.valid   = 1'b0;
      hit       = 0;
      exp_hit   = 0;
      mpos_x    = 0;
      mpos_y    = 0;
      win_start = cyc + 1;
      started   = 1;
    end else if (tick) begin
      // The pixel driven one cycle before the tick is counted on the tick edge,
      // so it belongs to the new frame.
      sum = 0;
      for (int c = win_start; c <= cyc - 2; c++) sum += hits[c];
      exp_hit   = (sum > SAT) ? SAT : sum;
      win_start = cyc - 1;
      mpos_x    = cur_pxi;
      mpos_y    = cur_pyi;
    end
    q.push_back(e);
    hits.push_back(hit ? 1 : 0);
    cyc++;
  endtask

  task automatic scan(input int y0, input int y1, input int x0, input int x1, input bit blank);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        step(0, !blank && x < 640 && y < 480, x, y, 0);
  endtask

  // Blank gap, frame tick latching (px,py), then a blank gap.
  task automatic new_frame(input int px, input int py);
    cur_pxi = px;
    cur_pyi = py;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset      = 1'b1;
    video_on   = 1'b1;
    pixel_x    = '0;
    pixel_y    = '0;
    frame_tick = 1'b0;
    pos_x_in   = '0;
    pos_y_in   = '0;
    bg_rgb     = 12'h000;

    // Reset held for three clocks with video_on high; sprite at (0,0) is in window.
    cur_bg = 12'h123;
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 2, 0, 0);
    check("rst_rgb", rgb_out, 12'h000);
    check("rst_valid", rgb_valid, 1'b0);
    check("rst_hits", hit_count, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 5 + i, 5, 0);

    // Address and alignment
    rom_mode = 0;
    new_frame(100, 50);
    cur_bg = 12'hABC;
    step(0, 1, 103, 52, 0);
    check("addr_in_win", rom_addr, 35);
    step(0, 1, 99, 52, 0);
    check("addr_out_win", rom_addr, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Clipping at the bottom-right corner of the visible area
    rom_mode = 2;
    new_frame(630, 470);
    scan(466, 485, 0, 3, 0);
    scan(466, 485, 625, 645, 0);
    scan(466, 485, 1018, 1023, 0);
    new_frame(630, 470);
    check("clip_hits", hit_count, 100);

    // A sprite near column 1023 must not wrap onto column 0
    new_frame(1020, 10);
    scan(8, 14, 0, 5, 0);
    new_frame(1020, 10);
    check("wrap_hits", hit_count, 0);

    // Position latch: a mid-frame change is ignored until the next tick
    new_frame(100, 50);
    cur_pxi = 200;
    cur_pyi = 200;
    scan(48, 67, 96, 118, 0);
    scan(198, 217, 196, 218, 0);
    new_frame(200, 200);
    check("old_pos_hits", hit_count, 256);
    scan(48, 67, 96, 118, 0);
    scan(198, 217, 196, 218, 0);
    new_frame(200, 200);
    check("new_pos_hits", hit_count, 256);

    // Colour key
    rom_mode = 1;
    cur_bg   = 12'h5A5;
    new_frame(300, 200);
    scan(199, 216, 299, 316, 0);
    new_frame(300, 200);
    check("key_hits", hit_count, KEY_HITS);

    // Blanking inside the sprite window
    rom_mode = 2;
    scan(199, 216, 299, 316, 1);
    new_frame(300, 200);
    check("blank_hits", hit_count, 0);

    // Randomized traffic with occasional ticks, moves and mid-frame resets
    rom_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      bit r, t;
      int px, py;
      r = ($urandom_range(0, 299) == 0);
      t = !r && ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cur_pxi = ($urandom_range(0, 2) == 0) ? 1015 + int'($urandom_range(0, 8))
                                              : int'($urandom_range(0, 1023));
        cur_pyi = int'($urandom_range(0, 1023));
      end
      cur_bg = 12'($urandom());
      if ($urandom_range(0, 4) == 0) px = int'($urandom_range(0, 7));
      else px = (mpos_x + int'($urandom_range(0, 24)) - 4) & 1023;
      py = (mpos_y + int'($urandom_range(0, 24)) - 4) & 1023;
      step(r, ($urandom_range(0, 9) != 0), px, py, t);
    end

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
